// File: rtl/shift_add_multiplier.sv
// Sequential 8x8 unsigned multiplier: one add-and-shift step per cycle over
// eight cycles, using an 8-bit carry-lookahead adder for the partial sums.

module cla_adder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic       cout,
  output logic [7:0] sum
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  logic       pp;

  // Each carry is a flat sum of generate terms gated by the propagate chain above them.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    pp   = 1'b0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g[i];
      pp     = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & cin);
    end
    sum  = p ^ c[7:0];
    cout = c[8];
  end

endmodule

module shift_add_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;    // M
  logic [DATA_W-1:0]   mplier_q, mplier_d;  // Q, low half of the running product
  logic [DATA_W-1:0]   acc_q, acc_d;        // A, high half of the running product
  logic [2:0]          cnt_q, cnt_d;
  logic [2*DATA_W-1:0] product_q, product_d;

  logic [DATA_W-1:0]   addend;
  logic [DATA_W-1:0]   sum;
  logic                carry;
  logic [DATA_W-1:0]   acc_next;
  logic [DATA_W-1:0]   mplier_next;

  assign addend = mplier_q[0] ? mcand_q : '0;

  cla_adder8 u_add (
    .a    (acc_q),
    .b    (addend),
    .cin  (1'b0),
    .cout (carry),
    .sum  (sum)
  );

  // The carry C lives only combinationally: the right shift of {C,A,Q}
  // moves it into A's MSB, leaving C at zero after every step.
  assign acc_next    = {carry, sum[DATA_W-1:1]};
  assign mplier_next = {sum[0], mplier_q[DATA_W-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = CALC;
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      CALC: begin
        acc_d    = acc_next;
        mplier_d = mplier_next;
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d   = DONE;
          product_d = {acc_next, mplier_next};
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == IDLE);
    busy  = (state_q == CALC);
    done  = (state_q == DONE);
  end

  assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: accepted starts push a*b and the
// acceptance cycle; each done pulse pops and checks product and latency.

module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  a_i = '0;
  logic [7:0]  b_i = '0;
  logic        ready, busy, done;
  logic [15:0] product;

  typedef struct {
    logic [15:0] prod;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          done_cnt = 0;
  int          aborted = 0;
  int          acc_cyc_last = 0;
  int          acc_cyc_prev = 0;
  logic [15:0] model_prod = '0;
  bit          mon_en = 1'b0;

  shift_add_multiplier dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a_i),
    .b       (b_i),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change only 2ns after a rising edge, so the falling edge sees
  // exactly what the next rising edge will sample.
  always @(negedge clk) begin
    if (mon_en) begin
      if (done === 1'b1) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          chk("spurious_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("product", 32'(product), 32'(e.prod));
          chk("latency", 32'(cyc - e.cyc), 32'd9);
          model_prod = e.prod;
        end
      end else begin
        chk("product_hold", 32'(product), 32'(model_prod));
      end
      if (rst) begin
        aborted += sb_q.size();
        sb_q.delete();
        model_prod = '0;
      end else if (start && ready) begin
        exp_t e;
        e.prod = 16'(a_i) * 16'(b_i);
        e.cyc  = cyc;
        sb_q.push_back(e);
        acc_cnt++;
        acc_cyc_prev = acc_cyc_last;
        acc_cyc_last = cyc;
      end
    end
  end

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready === 1'b1 && sb_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", 32'(ok), 32'd1);
  endtask

  // Leaves the bench 2ns after the accepting edge, then scrambles operands.
  task automatic drive(input logic [7:0] av, input logic [7:0] bv);
    @(posedge clk);
    #2;
    a_i   = av;
    b_i   = bv;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    a_i   = 8'($urandom);
    b_i   = 8'($urandom);
  endtask

  task automatic run_op(input logic [7:0] av, input logic [7:0] bv);
    drive(av, bv);
    @(negedge clk);
    chk("calc_busy", 32'(busy), 32'd1);
    chk("calc_ready", 32'(ready), 32'd0);
    wait_idle();
  endtask

  initial begin
    int d0, a0;

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    mon_en = 1'b1;

    run_op(8'd1, 8'd1);
    run_op(8'd255, 8'd255);
    run_op(8'd0, 8'd200);
    run_op(8'd180, 8'd89);
    run_op(8'd228, 8'd219);
    run_op(8'd200, 8'd0);

    // A second start three edges into a multiply must be ignored.
    d0 = done_cnt;
    a0 = acc_cnt;
    drive(8'd9, 8'd9);
    repeat (2) @(posedge clk);
    #2;
    a_i   = 8'd7;
    b_i   = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("busy_start_done", 32'(done_cnt - d0), 32'd1);
    chk("busy_start_acc", 32'(acc_cnt - a0), 32'd1);

    // Reset four edges after acceptance aborts the multiply.
    d0 = done_cnt;
    drive(8'd78, 8'd90);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_product", 32'(product), 32'd0);
    repeat (15) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

    // Start held high: the next acceptance follows the DONE->IDLE return.
    d0 = done_cnt;
    a0 = acc_cnt;
    @(posedge clk);
    #2;
    a_i   = 8'd123;
    b_i   = 8'd45;
    start = 1'b1;
    for (int i = 0; i < 40 && acc_cnt < a0 + 2; i++) @(negedge clk);
    chk("b2b_accepts", 32'(acc_cnt - a0), 32'd2);
    chk("b2b_spacing", 32'(acc_cyc_last - acc_cyc_prev), 32'd10);
    @(posedge clk);
    #2 start = 1'b0;
    wait_idle();
    chk("b2b_dones", 32'(done_cnt - d0), 32'd2);

    // Every a against a spread of b values including 0 and 255.
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 16; j++) begin
        drive(8'(i), 8'(j * 17));
        wait_idle();
      end
    end

    repeat (3) @(negedge clk);
    chk("done_per_start", 32'(done_cnt), 32'(acc_cnt - aborted));
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
